// File: rtl/axi4_wr_burst_scheduler.sv
`default_nettype none
// ============================================================================
// Module : axi4_wr_burst_scheduler
// Brief  : Splits a write transfer command into 4 KB-safe AXI4 AW bursts and
//          tracks outstanding B responses.
// Rev    : 1.0 - initial release
// ============================================================================
module axi4_wr_burst_scheduler #(
  parameter int ASIZE           = 32,
  parameter int IDSIZE          = 4,
  parameter int BPB             = 64,
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic              axi_aclk,
  input  logic              axi_aresetn,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ASIZE-1:0]  cmd_addr,
  input  logic [31:0]       cmd_beats,
  input  logic [8:0]        max_length,
  output logic              aw_valid,
  input  logic              aw_ready,
  output logic [IDSIZE-1:0] aw_id,
  output logic [ASIZE-1:0]  aw_addr,
  output logic [7:0]        aw_len,
  input  logic              b_valid,
  output logic              b_ready,
  output logic              busy,
  output logic              done,
  output logic              err_b
);

  localparam int         c_LOG2_BPB = $clog2(BPB);
  localparam logic [7:0] c_MAX_OUT  = 8'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_ISSUE = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next_state;
  logic [ASIZE-1:0]  r_cur_addr;
  logic [31:0]       r_remain;
  logic [8:0]        r_blen;
  logic [IDSIZE-1:0] r_id;
  logic [7:0]        r_outstanding;
  logic              r_done;
  logic              r_err_b;

  logic [8:0]        w_max_len_eff;
  logic [12:0]       w_page_beats;
  logic [8:0]        w_blen_calc;
  logic [31:0]       w_remain_next;
  logic [ASIZE-1:0]  w_addr_inc;
  logic              w_aw_hs;
  logic              w_b_cnt;
  logic              w_can_issue;

  // Burst length is the tightest of: beats left, length cap, beats to the 4 KB page end.
  assign w_max_len_eff = (max_length == 9'd0) ? 9'd256 : max_length;
  assign w_page_beats  = (13'd4096 - {1'b0, r_cur_addr[11:0]}) >> c_LOG2_BPB;

  always_comb begin
    w_blen_calc = w_max_len_eff;
    if (w_page_beats < {4'd0, w_blen_calc}) begin
      w_blen_calc = w_page_beats[8:0];
    end
    if (r_remain < {23'd0, w_blen_calc}) begin
      w_blen_calc = r_remain[8:0];
    end
  end

  assign w_remain_next = r_remain - {23'd0, r_blen};
  assign w_addr_inc    = ASIZE'(r_blen) << c_LOG2_BPB;
  assign w_aw_hs       = (r_state == S_ISSUE) && aw_ready;
  assign w_b_cnt       = b_valid && (r_outstanding != 8'd0);
  assign w_can_issue   = (r_outstanding < c_MAX_OUT);

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    cmd_ready    = 1'b0;
    aw_valid     = 1'b0;
    busy         = 1'b1;
    case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          w_next_state = (cmd_beats == 32'd0) ? S_DRAIN : S_CALC;
        end
      end
      S_CALC: begin
        if (w_can_issue) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        aw_valid = 1'b1;
        if (aw_ready) begin
          w_next_state = (w_remain_next == 32'd0) ? S_DRAIN : S_CALC;
        end
      end
      S_DRAIN: begin
        if (r_outstanding == 8'd0) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_cur_addr    <= '0;
      r_remain      <= '0;
      r_blen        <= '0;
      r_id          <= '0;
      r_outstanding <= '0;
      r_done        <= 1'b0;
      r_err_b       <= 1'b0;
    end else begin
      r_done <= (r_state == S_DRAIN) && (w_next_state == S_IDLE);
      if ((r_state == S_IDLE) && cmd_valid) begin
        r_cur_addr <= cmd_addr;
        r_remain   <= cmd_beats;
      end
      // Resampled every CALC cycle so a stalled burst picks up the latest max_length.
      if (r_state == S_CALC) begin
        r_blen <= w_blen_calc;
      end
      if (w_aw_hs) begin
        r_cur_addr <= r_cur_addr + w_addr_inc;
        r_remain   <= w_remain_next;
        r_id       <= r_id + 1'b1;
      end
      if (w_aw_hs && !w_b_cnt) begin
        r_outstanding <= r_outstanding + 8'd1;
      end else if (!w_aw_hs && w_b_cnt) begin
        r_outstanding <= r_outstanding - 8'd1;
      end
      if (b_valid && (r_outstanding == 8'd0)) begin
        r_err_b <= 1'b1;
      end
    end
  end

  assign aw_id   = r_id;
  assign aw_addr = r_cur_addr;
  assign aw_len  = r_blen[7:0] - 8'd1;
  assign b_ready = 1'b1;
  assign done    = r_done;
  assign err_b   = r_err_b;

endmodule
`default_nettype wire

// File: doc/axi4_wr_burst_scheduler.md
AXI4_WR_BURST_SCHEDULER -- requirements
Module: axi4_wr_burst_scheduler

Interface
REQ-001 The block SHALL have these parameters:
- ASIZE, 32, address width.
- IDSIZE, 4, AXI ID width.
- BPB, 64, bytes per beat (power of 2, 1..4096).
- MAX_OUTSTANDING, 8, maximum AW issued without a B response (1..255).

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- axi_aclk  in  1  sole clock.
- axi_aresetn  in  1  reset, asynchronous, active-low.
- cmd_valid  in  1  transfer command valid.
- cmd_ready  out  1  command accepted.
- cmd_addr  in  ASIZE  start byte address, BPB-aligned.
- cmd_beats  in  32  total beats of the transfer.
- max_length  in  9  maximum beats per burst, 1..256; value 0 SHALL mean 256.
- aw_valid  out  1  AW channel valid.
- aw_ready  in  1  AW channel ready.
- aw_id  out  IDSIZE  burst ID.
- aw_addr  out  ASIZE  burst address.
- aw_len  out  8  burst beats minus 1.
- b_valid  in  1  B response valid.
- b_ready  out  1  B ready, constant 1.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a command fully completes.
- err_b  out  1  sticky flag for an unexpected B.

Function
REQ-003 The FSM SHALL have four states: IDLE, CALC, ISSUE, DRAIN.

REQ-004 IDLE behaviour:
- cmd_ready=1 only in IDLE.
- On cmd_valid&&cmd_ready, latch cur_addr=cmd_addr and remain=cmd_beats.
- Go to DRAIN if cmd_beats==0, else go to CALC.

REQ-005 CALC behaviour:
- Register blen=min(remain, max_length eff, (4096-cur_addr[11:0])/BPB).
- A burst SHALL never cross a 4 KB boundary.
- Go to ISSUE only when outstanding<MAX_OUTSTANDING; otherwise stay in CALC.

REQ-006 ISSUE behaviour:
- aw_valid=1.
- aw_addr=cur_addr, aw_len=blen-1, aw_id=id.
- All AW outputs SHALL stay stable until aw_ready.
- aw_valid SHALL never drop before aw_ready.

REQ-007 On an AW handshake:
- cur_addr+=blen*BPB, modulo 2^ASIZE.
- remain-=blen.
- id+=1, wrapping modulo 2^IDSIZE.
- Go to DRAIN if remain==0, else go to CALC.

REQ-008 DRAIN SHALL wait for outstanding==0, then go to IDLE. The done register SHALL be set on that transition, so done is high for exactly the first IDLE cycle.

REQ-009 The outstanding counter SHALL:
- increment on an AW handshake;
- decrement on b_valid with outstanding>0;
- stay unchanged when both events occur in the same cycle.

REQ-010 b_valid with outstanding==0 SHALL be ignored for counting and SHALL set err_b, which stays set until reset.

REQ-011 The id counter SHALL persist across commands, so successive commands continue the ID sequence.

REQ-012 Latency SHALL be:
- cmd handshake to first aw_valid: 2 cycles, through CALC.
- AW handshake to next aw_valid: 2 cycles.

REQ-013 max_length SHALL be sampled in CALC, so a change takes effect at the next burst.

Reset
REQ-014 Assertion of axi_aresetn low SHALL immediately force:
- state=IDLE;
- aw_valid=0, done=0, err_b=0, busy=0;
- outstanding=0, id=0, cur_addr=0, remain=0, blen=0.

REQ-015 A reset mid-transfer SHALL abandon the transfer with no further AW. Any B arriving after reset SHALL set err_b.

REQ-016 cmd_ready SHALL be 1 in the first cycle after reset deasserts.

Verification (BPB=64, MAX_OUTSTANDING=8 unless stated)
REQ-017 cmd_addr=0x0, cmd_beats=100, max_length=32, aw_ready=1, B returned 4 cycles after each AW -> exactly four AW:
- (id0, 0x0000, len31)
- (id1, 0x0800, len31)
- (id2, 0x1000, len31)
- (id3, 0x1800, len3)
- then done once, after the 4th B.

REQ-018 cmd_addr=0xF80, cmd_beats=10, max_length=0 -> AW (0xF80, len1) then (0x1000, len7).

REQ-019 MAX_OUTSTANDING=2, cmd_beats=96, max_length=32, B withheld:
- two AW issue, the third aw_valid stays 0;
- after one B, the third AW issues within 2 cycles.

REQ-020 cmd_beats=0 -> no aw_valid; done high 2 cycles after the command handshake; cmd_ready high again in that same cycle.

REQ-021 An AW handshake and a B in the same cycle with outstanding=3 -> outstanding remains 3.

REQ-022 Reset asserted while in ISSUE with aw_ready=0 -> same cycle: aw_valid=0, busy=0; the next command starts at id0. A B in IDLE with outstanding=0 -> err_b=1 and stays set.
